// File: rtl/inst_uart_loader.sv
// Purpose : boots an instruction memory from a UART byte stream. It reads a 16-bit little-endian
//           word count, then that many 32-bit little-endian words, and then releases the core reset.
// Latency : wr_en pulses one cycle after the stop-bit sample of each word's fourth byte;
//           load_done and core_rstn rise one cycle after the loader enters DONE.
// Backpressure: none. The serial line cannot be stalled, so the memory must accept a write every
//           time wr_en pulses. Words at or beyond 2^ADDR_W are received but not written.
// Ports   : clk, rstn (async active-low), uart_rx (8N1, LSB first, idle high);
//           wr_en, wr_addr, wr_data (instruction-memory write port);
//           core_rstn, load_done, frame_err (status, all registered).
// Limits  : CLK_DIV >= 8, ADDR_W <= 16 (the word counter is 16 bits).
module inst_uart_loader #(
  parameter int CLK_DIV = 868,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rstn,
  output logic              load_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [16:0]      DEPTH    = 17'(1) << ADDR_W;

  // ---------------------------------------------------------------------------
  // Serial receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_vld;
  logic             byte_bad;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    byte_bad   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-point of the start bit: a high line means the edge was a glitch.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_FULL) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_FULL) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_vld   = rx_sync_q;
          byte_bad   = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // The line idles high, so the synchronizer resets high to avoid a false start edge.
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, DONE} ld_state_t;

  ld_state_t         ld_state_q;
  logic [15:0]       count_q;
  logic [15:0]       word_idx_q;
  logic [1:0]        phase_q;
  logic [23:0]       asm_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              load_done_q;
  logic              core_rstn_q;
  logic              frame_err_q;
  logic              in_range;

  assign in_range = {1'b0, word_idx_q} < DEPTH;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_state_q  <= LEN_LO;
      count_q     <= '0;
      word_idx_q  <= '0;
      phase_q     <= '0;
      asm_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      core_rstn_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      load_done_q <= (ld_state_q == DONE);
      core_rstn_q <= (ld_state_q == DONE);
      // Once loading is done the line is ignored, including its framing errors.
      if (byte_bad && ld_state_q != DONE) frame_err_q <= 1'b1;
      if (byte_vld) begin
        case (ld_state_q)
          LEN_LO: begin
            count_q[7:0] <= rx_shift_q;
            ld_state_q   <= LEN_HI;
          end
          LEN_HI: begin
            count_q[15:8] <= rx_shift_q;
            ld_state_q    <= ({rx_shift_q, count_q[7:0]} == 16'd0) ? DONE : DATA;
          end
          DATA: begin
            phase_q <= phase_q + 1'b1;
            case (phase_q)
              2'd0: asm_q[7:0]   <= rx_shift_q;
              2'd1: asm_q[15:8]  <= rx_shift_q;
              2'd2: asm_q[23:16] <= rx_shift_q;
              default: begin
                // The output data register only changes on a word boundary,
                // so it stays stable around the write strobe.
                wr_data_q  <= {rx_shift_q, asm_q};
                word_idx_q <= word_idx_q + 16'd1;
                if (in_range) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= word_idx_q[ADDR_W-1:0];
                end
                if (word_idx_q + 16'd1 == count_q) ld_state_q <= DONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;
  assign core_rstn = core_rstn_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_inst_uart_loader.sv
// Bench for inst_uart_loader: drives 8N1 frames with random gaps and payloads. A queue of
// expected writes is built from the image rules (word index, little-endian data, depth limit)
// and compared against every wr_en. Load completion is also checked against image completion.
module tb_inst_uart_loader;
  localparam int CLK_DIV = 16;
  localparam int ADDR_W  = 4;
  localparam int HALF    = CLK_DIV / 2;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              uart_rx = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_rstn;
  logic              load_done;
  logic              frame_err;

  inst_uart_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rstn(core_rstn), .load_done(load_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  int  checks = 0;
  int  failures = 0;
  int  stop_start = 0;
  int  last_wr_cyc = 0;
  int  done_rise_cyc = 0;
  bit  img_complete = 0;
  bit  prev_done = 0;
  wr_t e_m;
  wr_t g_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the expected-write queue and completion state.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en) begin
        g_m.addr = wr_addr;
        g_m.data = wr_data;
        got_q.push_back(g_m);
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_wr actual=addr %0d data %h required=no write", wr_addr, wr_data);
        end else begin
          e_m = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e_m.addr));
          chk("wr_data", wr_data, e_m.data);
        end
        chk("wr_window", 32'((cyc - stop_start >= HALF) && (cyc - stop_start <= CLK_DIV - 1)), 32'd1);
      end
      if (load_done && !prev_done) begin
        done_rise_cyc = cyc;
        chk("done_after_image", 32'(img_complete), 32'd1);
        chk("done_all_writes", 32'(exp_q.size()), 32'd0);
        chk("done_window", 32'((cyc - stop_start >= HALF + 1) && (cyc - stop_start <= CLK_DIV)), 32'd1);
      end
      if (!img_complete) chk("no_early_done", 32'(load_done), 32'd0);
      chk("core_rstn_vs_done", 32'(core_rstn), 32'(load_done));
    end
    prev_done = load_done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit last);
    uart_rx = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CLK_DIV);
    end
    stop_start = cyc;
    if (last) img_complete = 1;
    uart_rx = stop_bit;
    tick(CLK_DIV);
    uart_rx = 1'b1;
    tick($urandom_range(2, 6));
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(3 * CLK_DIV);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    exp_q.delete();
    got_q.delete();
    img_complete = 0;
    uart_rx = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(3);
  endtask

  // Model: word w = payload bytes 4w..4w+3 little-endian at address w, written only below DEPTH.
  task automatic run_image(input int nwords, input logic [7:0] pl[$]);
    wr_t w;
    for (int i = 0; i < nwords; i++) begin
      if (i < DEPTH) begin
        w.addr = ADDR_W'(i);
        w.data = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
        exp_q.push_back(w);
      end
    end
    send_byte(8'(nwords), 1'b1, 0);
    send_byte(8'(nwords >> 8), 1'b1, nwords == 0);
    for (int i = 0; i < 4 * nwords; i++) send_byte(pl[i], 1'b1, i == 4 * nwords - 1);
    tick(4);
    chk("image_writes_drained", 32'(exp_q.size()), 32'd0);
    chk("image_load_done", 32'(load_done), 32'd1);
    chk("image_core_rstn", 32'(core_rstn), 32'd1);
  endtask

  logic [7:0] pl[$];
  wr_t w0;

  initial begin
    do_reset();

    // Two-word image with fixed contents, then extra bytes that must be ignored.
    pl = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run_image(2, pl);
    chk("t31_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t31_addr0", 32'(got_q[0].addr), 32'd0);
      chk("t31_data0", got_q[0].data, 32'h00500013);
      chk("t31_addr1", 32'(got_q[1].addr), 32'd1);
      chk("t31_data1", got_q[1].data, 32'h00A00093);
    end
    chk("t31_done_next_cycle", 32'(done_rise_cyc - last_wr_cyc), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1);
    chk("done_ignores_input", 32'(got_q.size()), 32'd2);
    chk("done_stays", 32'(load_done), 32'd1);

    // Reset out of DONE, then an empty image.
    do_reset();
    pl.delete();
    run_image(0, pl);
    chk("t32_no_writes", 32'(got_q.size()), 32'd0);

    // A byte with a bad stop bit is dropped without disturbing word assembly.
    do_reset();
    w0.addr = '0;
    w0.data = 32'h44332211;
    exp_q.push_back(w0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h11, 1'b1, 0);
    chk("t33_ferr_before", 32'(frame_err), 32'd0);
    send_byte(8'h55, 1'b0, 0);
    chk("t33_ferr_after", 32'(frame_err), 32'd1);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 1);
    tick(4);
    chk("t33_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("t33_data", got_q[0].data, 32'h44332211);
    chk("t33_done", 32'(load_done), 32'd1);
    chk("t33_ferr_sticky", 32'(frame_err), 32'd1);

    // Start-bit glitches in several loader states produce nothing.
    do_reset();
    w0.data = $urandom;
    exp_q.push_back(w0);
    glitch();
    send_byte(8'h01, 1'b1, 0);
    glitch();
    send_byte(8'h00, 1'b1, 0);
    glitch();
    send_byte(w0.data[7:0], 1'b1, 0);
    glitch();
    send_byte(w0.data[15:8], 1'b1, 0);
    send_byte(w0.data[23:16], 1'b1, 0);
    send_byte(w0.data[31:24], 1'b1, 1);
    tick(4);
    chk("t34_count", 32'(got_q.size()), 32'd1);
    chk("t34_done", 32'(load_done), 32'd1);
    chk("t34_no_ferr", 32'(frame_err), 32'd0);

    // Image longer than the memory: only the first DEPTH words are written.
    do_reset();
    pl.delete();
    for (int i = 0; i < 18 * 4; i++) pl.push_back(8'($urandom));
    run_image(18, pl);
    chk("t35_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) chk("t35_last_addr", 32'(got_q[15].addr), 32'd15);

    // Reset in the middle of the third byte of word 0, then the full image again.
    do_reset();
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h13, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    uart_rx = 1'b0;
    tick(CLK_DIV);
    uart_rx = 1'b0;
    tick(3 * CLK_DIV);
    chk("t36_no_partial_write", 32'(got_q.size()), 32'd0);
    do_reset();
    pl = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run_image(2, pl);
    chk("t36_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t36_data0", got_q[0].data, 32'h00500013);
      chk("t36_data1", got_q[1].data, 32'h00A00093);
    end

    // Random images.
    for (int it = 0; it < 4; it++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 5);
      pl.delete();
      for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
      run_image(n, pl);
      chk("rand_count", 32'(got_q.size()), 32'(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
